// File: rtl/fetch_pkg.sv
// Shared constants and FSM state type for the fetch front end.
package fetch_pkg;

  localparam logic [31:0]     NOP_INSTR       = 32'hD503201F;
  localparam int unsigned     INSTR_BYTES_DEF = 4;

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_PEND = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_redirect_hold.sv
// Parks a redirect target that arrives while the front end is frozen.
// The PEND state bit lives here alongside the target register.
module fetch_redirect_hold
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic            capture,
  input  logic            resume,
  input  logic [XLEN-1:0] capture_target,
  output logic            pending,
  output logic [XLEN-1:0] target
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] target_q, target_d;

  // State and target register
  always_ff @(posedge clk) begin
    if (Reset) begin
      state_q  <= FS_RUN;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Next-state logic; a newer redirect never overwrites a parked one
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      FS_RUN: begin
        if (capture) begin
          state_d  = FS_PEND;
          target_d = capture_target;
        end
      end
      FS_PEND: begin
        if (resume) state_d = FS_RUN;
      end
      default: state_d = FS_RUN;
    endcase
  end

  assign pending = (state_q == FS_PEND);
  assign target  = target_q;

endmodule

// File: rtl/fetch_next_pc.sv
// Next-PC mux and IF/ID pipeline register for the fetch front end.
// Optional redirect counter enabled by defining FETCH_STATS_EN.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int unsigned     INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic            clk,
  input  logic            Reset,
  input  logic [XLEN-1:0] PC,
  input  logic [31:0]     Instr,
  input  logic            Stall,
  input  logic            BrTaken,
  input  logic [XLEN-1:0] BrTarget,
  output logic [XLEN-1:0] NextPC,
  output logic            PCStall,
  output logic [XLEN-1:0] IFID_PC,
  output logic [31:0]     IFID_Instr,
  output logic            IFID_Valid
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]     RedirectCount
`endif
);

  logic            pending;
  logic [XLEN-1:0] pend_target;
  logic            redirect_c;
  logic            capture_c;
  logic            resume_c;

  assign capture_c = Stall && BrTaken && !pending;
  assign resume_c  = pending && !Stall;

  fetch_redirect_hold #(
    .XLEN (XLEN)
  ) u_hold (
    .clk            (clk),
    .Reset          (Reset),
    .capture        (capture_c),
    .resume         (resume_c),
    .capture_target (BrTarget),
    .pending        (pending),
    .target         (pend_target)
  );

  // Next-PC mux; a parked redirect is older than any new BrTaken
  always_comb begin
    NextPC     = PC + XLEN'(INSTR_BYTES);
    PCStall    = 1'b0;
    redirect_c = 1'b0;
    if (Reset) begin
      NextPC = RESET_PC;
    end else begin
      PCStall = Stall;
      if (!Stall) begin
        if (pending) begin
          NextPC     = pend_target;
          redirect_c = 1'b1;
        end else if (BrTaken) begin
          NextPC     = BrTarget;
          redirect_c = 1'b1;
        end
      end
    end
  end

  // IF/ID register; a redirect squashes the slot into a bubble
  always_ff @(posedge clk) begin
    if (Reset) begin
      IFID_PC    <= '0;
      IFID_Instr <= NOP_INSTR;
      IFID_Valid <= 1'b0;
    end else if (!Stall) begin
      IFID_PC    <= PC;
      IFID_Instr <= redirect_c ? NOP_INSTR : Instr;
      IFID_Valid <= !redirect_c;
    end
  end

`ifdef FETCH_STATS_EN
  // Saturating count of applied redirects
  always_ff @(posedge clk) begin
    if (Reset) begin
      RedirectCount <= '0;
    end else if (redirect_c && (RedirectCount != 32'hFFFF_FFFF)) begin
      RedirectCount <= RedirectCount + 32'd1;
    end
  end
`endif

endmodule

// File: doc/fetch_next_pc.md
# fetch_next_pc

Front-end sequencer feeding the 64-bit program-counter register (`Reg_64S`). Each cycle it computes that register's `D`/`Stall` inputs (sequential PC+4 or a resolved branch target) and holds the IF/ID pipeline register (PC, instruction, valid) consumed by decode. It owns front-end flush on redirect and parks a redirect that arrives while the front end is frozen.

## Interface
Parameters:
- `XLEN`, 64, address width.
- `RESET_PC`, 64'h0, `NextPC` value while `Reset` is high.
- `INSTR_BYTES`, 4, sequential PC increment.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `Reset`  in  1  synchronous, active-high.
- `PC`  in  XLEN  current PC, the `Q` output of the PC register.
- `Instr`  in  32  instruction-memory read data for `PC`, combinational and same cycle.
- `Stall`  in  1  front-end freeze request from the hazard/memory unit.
- `BrTaken`  in  1  taken-branch redirect from EX/MEM; single-cycle pulse.
- `BrTarget`  in  XLEN  redirect address; valid when `BrTaken` is high.
- `NextPC`  out  XLEN  drives the PC register's `D`.
- `PCStall`  out  1  drives the PC register's `Stall`.
- `IFID_PC`, `IFID_Instr`, `IFID_Valid`  out  XLEN/32/1  IF/ID register outputs.
- `RedirectCount`  out  32  present only with `FETCH_STATS_EN`.

## Operation
- FSM has two states.
  - RUN: normal fetch.
  - PEND: a redirect is captured and waiting for the stall to drop.
- RUN, `Stall`=0, `BrTaken`=0: `NextPC`=`PC`+`INSTR_BYTES`, `PCStall`=0. IF/ID loads {`PC`, `Instr`, 1}.
- RUN, `Stall`=0, `BrTaken`=1: `NextPC`=`BrTarget`, `PCStall`=0. IF/ID loads a bubble {`PC`, NOP 32'hD503201F, 0}. FSM stays in RUN.
- RUN, `Stall`=1, `BrTaken`=0: `PCStall`=1. `NextPC`=`PC`+`INSTR_BYTES` (don't-care, because the PC register holds). IF/ID holds.
- RUN, `Stall`=1, `BrTaken`=1: capture `BrTarget` into the pending register and go to PEND. `PCStall`=1, IF/ID holds.
- PEND, `Stall`=1: `PCStall`=1, IF/ID holds. `BrTaken` is ignored here, because the pending branch is older.
- PEND, `Stall`=0: `NextPC`=pending target, `PCStall`=0. IF/ID loads a bubble. FSM returns to RUN.
- Arithmetic: `PC`+`INSTR_BYTES` is modulo 2^XLEN, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0. No alignment check.
- Reset wins over every other input. It drops any pending redirect and forces the FSM to RUN.

## Timing
- Reset values:
  - `NextPC`=`RESET_PC` for as long as `Reset` is high.
  - `PCStall`=0.
  - `IFID_PC`=0, `IFID_Instr`=NOP, `IFID_Valid`=0.
  - Pending register=0, `RedirectCount`=0.
- IF/ID latency is 1 cycle: {`PC`, `Instr`} sampled at edge n appear at the outputs after edge n.
- Redirect with no stall, `BrTaken` in cycle n:
  - after edge n+1, `PC`=`BrTarget` and IF/ID holds a bubble;
  - after edge n+2, `IFID_PC`=`BrTarget` with `IFID_Valid`=1.
- Redirect under stall: the target appears on `PC` one edge after the first `Stall`=0 cycle. Exactly one bubble is inserted.
- `NextPC` and `PCStall` are combinational from `PC`, `Stall`, `BrTaken`, `BrTarget`, state and the pending register. IF/ID outputs are registered.

## Configuration
- `FETCH_STATS_EN` defined:
  - `RedirectCount` port exists;
  - it increments by 1 on every edge where a redirect is applied, i.e. `NextPC` takes a target and `PCStall`=0;
  - it saturates at 32'hFFFF_FFFF;
  - it clears on `Reset`.
- `FETCH_STATS_EN` undefined: no port, no counter logic. All other behaviour is identical.

## Structure
- Package `fetch_pkg` holds:
  - `NOP_INSTR` (32'hD503201F);
  - `INSTR_BYTES` default;
  - the FSM state enum (`FS_RUN`, `FS_PEND`).
- Sub-module `fetch_redirect_hold` holds the pending-target register plus its PEND state bit.
  - Inputs: capture, release, `Reset`.
  - Outputs: pending flag, target.
- The top level holds the next-PC mux, the IF/ID register and the optional counter.

## Test plan
- Reset, then release with `PC`=0 and no stall: `NextPC` steps 4, 8, 12. IF/ID shows `IFID_PC`=0,4,8 with `IFID_Valid`=1, one cycle behind.
- `BrTaken`=1 with `BrTarget`=64'h100 at `PC`=8, `Stall`=0:
  - `NextPC`=64'h100 that cycle;
  - next IF/ID is a bubble (`IFID_Valid`=0, NOP);
  - the following IF/ID has `IFID_PC`=64'h100, `IFID_Valid`=1.
- `Stall`=1 for 3 cycles: `PCStall`=1, and the IF/ID outputs stay constant at their pre-stall values.
- Redirect during a stall:
  - `Stall`=1, then `BrTaken` with 64'h200, then a second `BrTaken` with 64'h300 while still stalled;
  - when `Stall` drops, `NextPC`=64'h200, exactly one bubble is inserted, and 64'h300 is never fetched.
- `PC`=64'hFFFF_FFFF_FFFF_FFFC with no stall: `NextPC`=0.
- `Reset` asserted in PEND, at the same cycle as `BrTaken`:
  - pending is dropped, `NextPC`=`RESET_PC`, `IFID_Valid`=0;
  - with `FETCH_STATS_EN`, `RedirectCount` returns to 0.
